mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_pkg.sv | 20 ++
 rtl/mem_wb_reg.sv | 26 ++
 rtl/mem_wb_stage.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared MEM/WB pipeline types: FSM state, widths and the bubble bundle.
package mem_wb_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic             regwrite;
        logic [REG_W-1:0] writereg;
        logic [XLEN-1:0]  result;
    } wb_t;

    localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB write-back register; loads a bubble or the live bundle each cycle.
module mem_wb_reg
    import mem_wb_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_bubble,
    input  wb_t  i_wb,
    output wb_t  o_wb
);

    wb_t r_wb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wb <= WB_BUBBLE;
        end else if (i_bubble) begin
            r_wb <= WB_BUBBLE;
        end else begin
            r_wb <= i_wb;
        end
    end

    assign o_wb = r_wb;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data-memory handshake FSM with timeout, result mux and WB register.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_MEM,
    input  logic              MemToReg_MEM,
    input  logic              MemWrite_MEM,
    input  logic              JAL_MEM,
    input  logic [XLEN-1:0]   AluOut_MEM,
    input  logic [XLEN-1:0]   RtD_MEM,
    input  logic [XLEN-1:0]   PCPlus4_MEM,
    input  logic [REG_W-1:0]  WriteReg_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_mem,
    output logic              RegWrite_WB,
    output logic [REG_W-1:0]  WriteReg_WB,
    output logic [XLEN-1:0]   Result_WB,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       r_state;
    mem_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_misalign;
    logic             r_bus_err;

    logic w_memop;
    logic w_load;
    logic w_aligned;
    logic w_req;
    logic w_stall;
    logic w_bubble;
    logic w_set_mis;
    logic w_set_bus;
    wb_t  w_wb_in;
    wb_t  w_wb_out;

    assign w_memop   = MemToReg_MEM | MemWrite_MEM;
    assign w_load    = MemToReg_MEM & ~MemWrite_MEM;
    assign w_aligned = (AluOut_MEM[1:0] == 2'b00);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_bubble   = 1'b0;
        w_set_mis  = 1'b0;
        w_set_bus  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_memop && !w_aligned) begin
                    w_bubble  = 1'b1;
                    w_set_mis = 1'b1;
                end else if (w_memop) begin
                    w_req = 1'b1;
                    if (!dmem_ack) begin
                        w_stall    = 1'b1;
                        w_bubble   = 1'b1;
                        w_next     = ST_WAIT;
                        w_cnt_next = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    w_req  = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    // Give up: drop the request and let the pipe move on.
                    w_bubble  = 1'b1;
                    w_set_bus = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_req      = 1'b1;
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (reset) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_misalign <= r_misalign | w_set_mis;
            r_bus_err  <= r_bus_err | w_set_bus;
        end
    end

    always_comb begin
        w_wb_in.regwrite = RegWrite_MEM;
        w_wb_in.writereg = WriteReg_MEM;
        if (JAL_MEM) begin
            w_wb_in.result = PCPlus4_MEM;
        end else if (w_load) begin
            w_wb_in.result = dmem_rdata;
        end else begin
            w_wb_in.result = AluOut_MEM;
        end
    end

    mem_wb_reg u_wb_reg (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_bubble (w_bubble),
        .i_wb     (w_wb_in),
        .o_wb     (w_wb_out)
    );

    assign dmem_req     = w_req;
    assign dmem_we      = MemWrite_MEM & w_req;
    assign dmem_addr    = AluOut_MEM[ADDR_W-1:0];
    assign dmem_wdata   = RtD_MEM;
    assign stall_mem    = w_stall;
    assign RegWrite_WB  = w_wb_out.regwrite;
    assign WriteReg_WB  = w_wb_out.writereg;
    assign Result_WB    = w_wb_out.result;
    assign misalign_err = r_misalign;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a write-back scoreboard queue.
module tb_mem_wb_stage;
    import mem_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_MEM, MemToReg_MEM, MemWrite_MEM, JAL_MEM;
    logic [31:0] AluOut_MEM, RtD_MEM, PCPlus4_MEM;
    logic [4:0]  WriteReg_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_mem;
    logic        RegWrite_WB;
    logic [4:0]  WriteReg_WB;
    logic [31:0] Result_WB;
    logic        misalign_err, bus_err;

    int n_cmp = 0;
    int n_err = 0;
    wb_t sb[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite_MEM (RegWrite_MEM),
        .MemToReg_MEM (MemToReg_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .JAL_MEM      (JAL_MEM),
        .AluOut_MEM   (AluOut_MEM),
        .RtD_MEM      (RtD_MEM),
        .PCPlus4_MEM  (PCPlus4_MEM),
        .WriteReg_MEM (WriteReg_MEM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall_mem    (stall_mem),
        .RegWrite_WB  (RegWrite_WB),
        .WriteReg_WB  (WriteReg_WB),
        .Result_WB    (Result_WB),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic wb_t mk(input logic rw, input logic [4:0] wr,
                               input logic [31:0] res);
        wb_t w;
        w.regwrite = rw;
        w.writereg = wr;
        w.result   = res;
        return w;
    endfunction

    task automatic drive(input logic rw, input logic mtr, input logic mw,
                         input logic jal, input logic [31:0] alu,
                         input logic [31:0] rtd, input logic [31:0] pc4,
                         input logic [4:0] wr);
        RegWrite_MEM = rw;
        MemToReg_MEM = mtr;
        MemWrite_MEM = mw;
        JAL_MEM      = jal;
        AluOut_MEM   = alu;
        RtD_MEM      = rtd;
        PCPlus4_MEM  = pc4;
        WriteReg_MEM = wr;
    endtask

    // Inputs are set at edge+1; comb outputs checked at edge+4.
    task automatic tick(input string tag, input logic e_req,
                        input logic e_stall, input logic e_we,
                        input wb_t e_wb);
        wb_t e;
        #3;
        chk({tag, ".req"}, 32'(dmem_req), 32'(e_req));
        chk({tag, ".stall"}, 32'(stall_mem), 32'(e_stall));
        chk({tag, ".we"}, 32'(dmem_we), 32'(e_we));
        chk({tag, ".addr"}, dmem_addr, AluOut_MEM);
        chk({tag, ".wdata"}, dmem_wdata, RtD_MEM);
        sb.push_back(e_wb);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".RegWrite_WB"}, 32'(RegWrite_WB), 32'(e.regwrite));
        chk({tag, ".WriteReg_WB"}, 32'(WriteReg_WB), 32'(e.writereg));
        chk({tag, ".Result_WB"}, Result_WB, e.result);
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd5);
        @(posedge clk);
        #1;
        tick("rst0", 1'b0, 1'b0, 1'b0, WB_BUBBLE);
        tick("rst1", 1'b0, 1'b0, 1'b0, WB_BUBBLE);
        chk("rst.misalign", 32'(misalign_err), 32'd0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);

        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0, 5'd3);
        tick("alu", 1'b0, 1'b0, 1'b0, mk(1'b1, 5'd3, 32'h77));

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd5);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        tick("ld1", 1'b1, 1'b0, 1'b0, mk(1'b1, 5'd5, 32'hDEADBEEF));
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;

        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h1234, 32'h0, 5'd7);
        tick("st.w1", 1'b1, 1'b1, 1'b1, WB_BUBBLE);
        tick("st.w2", 1'b1, 1'b1, 1'b1, WB_BUBBLE);
        tick("st.w3", 1'b1, 1'b1, 1'b1, WB_BUBBLE);
        dmem_ack = 1'b1;
        tick("st.ack", 1'b1, 1'b0, 1'b1, mk(1'b0, 5'd7, 32'h44));
        dmem_ack = 1'b0;

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 5'd9);
        tick("to.w1", 1'b1, 1'b1, 1'b0, WB_BUBBLE);
        tick("to.w2", 1'b1, 1'b1, 1'b0, WB_BUBBLE);
        tick("to.w3", 1'b1, 1'b1, 1'b0, WB_BUBBLE);
        tick("to.w4", 1'b1, 1'b1, 1'b0, WB_BUBBLE);
        tick("to.abandon", 1'b0, 1'b0, 1'b0, WB_BUBBLE);
        chk("to.bus_err", 32'(bus_err), 32'd1);
        chk("to.state", 32'(dut.r_state), 32'(ST_IDLE));

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h42, 32'h0, 32'h0, 5'd6);
        tick("mis", 1'b0, 1'b0, 1'b0, WB_BUBBLE);
        chk("mis.misalign", 32'(misalign_err), 32'd1);
        chk("mis.bus_sticky", 32'(bus_err), 32'd1);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 32'h100, 5'd31);
        tick("jal", 1'b0, 1'b0, 1'b0, mk(1'b1, 5'd31, 32'h100));
        chk("jal.mis_sticky", 32'(misalign_err), 32'd1);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 5'd10);
        tick("rw.w0", 1'b1, 1'b1, 1'b0, WB_BUBBLE);
        tick("rw.w1", 1'b1, 1'b1, 1'b0, WB_BUBBLE);
        reset = 1'b1;
        tick("rw.rst", 1'b0, 1'b0, 1'b0, WB_BUBBLE);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD0BAD;
        tick("rw.late_ack", 1'b0, 1'b0, 1'b0, WB_BUBBLE);
        dmem_ack = 1'b0;
        chk("rw.bus_err", 32'(bus_err), 32'd0);
        chk("rw.misalign", 32'(misalign_err), 32'd0);
        chk("rw.state", 32'(dut.r_state), 32'(ST_IDLE));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE0000, 32'h0, 32'h0, 5'd2);
        tick("post", 1'b0, 1'b0, 1'b0, mk(1'b1, 5'd2, 32'hCAFE0000));

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
